// File: rtl/track_pkg.sv
`default_nettype none
// ============================================================================
// Module      : track_pkg
// Description : Shared types and constants for the track_tap stimulus and
//               observation stage: default widths, request entry layout,
//               request kind encoding and issue FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package track_pkg;

    localparam int c_label_width_def = 20;
    localparam int c_qaw_def         = 3;

    // The generator only offers a label while at least this many queue slots
    // are free. gen_valid is registered, so one more push plus a pop can
    // still land after the check. Four slots cover that worst case.
    localparam int c_gen_free_min    = 4;

    localparam logic c_req_mark  = 1'b1;
    localparam logic c_req_clear = 1'b0;

    // Request entry at the default label width. The top level declares the
    // same layout at its own LABELWIDTH.
    typedef struct packed {
        logic                         mark;
        logic [c_label_width_def-1:0] label;
    } req_entry_t;

    typedef enum logic [0:0] {
        ISSUE_IDLE = 1'b0,
        ISSUE_GAP  = 1'b1
    } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/track_tap_queue.sv
`default_nettype none
// ============================================================================
// Module      : dual_push_queue
// Description : Circular-buffer FIFO with two ordered write ports and one
//               read port. Port 0 is inserted ahead of port 1 in the same
//               cycle. Writes that find no free slot are dropped and flagged.
// Ports       : clk, rst (async, active high)
//               wr0_en/wr0_data, wr1_en/wr1_data : write ports (0 first)
//               rd_en, rd_data                    : read port (head, show-ahead)
//               empty, free_cnt                   : occupancy status
//               drop0, drop1                      : per-port drop this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dual_push_queue #(
    parameter int WIDTH = 21,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr0_en,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      free_cnt,
    output logic             drop0,
    output logic             drop1
);

    localparam int            c_depth = 1 << AW;
    localparam logic [AW:0]   c_full  = (AW+1)'(c_depth);

    logic [WIDTH-1:0] mem_q [c_depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;

    logic             w_acc0, w_acc1, w_rd;
    logic [AW:0]      w_cnt_after0;
    logic [AW-1:0]    w_wr1_ptr;

    // Space is judged on the occupancy at the start of the cycle; a read in
    // the same cycle does not make room for a write until the next cycle.
    always_comb begin
        w_acc0       = wr0_en && (count_q != c_full);
        w_cnt_after0 = count_q + (AW+1)'(w_acc0);
        w_acc1       = wr1_en && (w_cnt_after0 != c_full);
        w_wr1_ptr    = wptr_q + AW'(w_acc0);
        w_rd         = rd_en && (count_q != '0);
        wptr_d       = wptr_q + AW'(w_acc0) + AW'(w_acc1);
        rptr_d       = rptr_q + AW'(w_rd);
        count_d      = count_q + (AW+1)'(w_acc0) + (AW+1)'(w_acc1)
                       - (AW+1)'(w_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the empty flag guards every read.
    always_ff @(posedge clk) begin
        if (w_acc0) mem_q[wptr_q]    <= wr0_data;
        if (w_acc1) mem_q[w_wr1_ptr] <= wr1_data;
    end

    assign rd_data  = mem_q[rptr_q];
    assign empty    = (count_q == '0);
    assign free_cnt = c_full - count_q;
    assign drop0    = wr0_en && !w_acc0;
    assign drop1    = wr1_en && !w_acc1;

endmodule
`default_nettype wire

// File: rtl/track_tap.sv
`default_nettype none
// ============================================================================
// Module      : track_tap
// Description : Drives sequential labels into a FIFO under test, observes its
//               pop side, and forwards mark (push) / clear (pop) requests to
//               the label-tracking block at most once every other cycle.
// Ports       : clk, reset (async, active high)
//               gen_en, gen_data, gen_valid, gen_ready : label generator
//               mon_data, mon_valid, mon_ready         : pop-side monitor
//               track_fifo_we, track_label, track_mark,
//               track_fifo_full                        : tracking write port
//               tap_ovf                                : sticky drop flag
//               push_count, pop_count                  : wrapping counters
// Revision    : 1.0 - initial release
// ============================================================================
module track_tap
    import track_pkg::*;
#(
    parameter int LABELWIDTH = c_label_width_def,
    parameter int QAW        = c_qaw_def
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gen_en,
    output logic [LABELWIDTH-1:0] gen_data,
    output logic                  gen_valid,
    input  logic                  gen_ready,
    input  logic [LABELWIDTH-1:0] mon_data,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    output logic                  track_fifo_we,
    output logic [LABELWIDTH-1:0] track_label,
    output logic                  track_mark,
    input  logic                  track_fifo_full,
    output logic                  tap_ovf,
    output logic [31:0]           push_count,
    output logic [31:0]           pop_count
);

    typedef struct packed {
        logic                  mark;
        logic [LABELWIDTH-1:0] label;
    } req_t;

    logic [LABELWIDTH-1:0] gen_data_q, gen_data_d;
    logic                  gen_valid_q, gen_valid_d;
    logic [31:0]           push_count_q, push_count_d;
    logic [31:0]           pop_count_q, pop_count_d;
    logic                  tap_ovf_q, tap_ovf_d;
    issue_state_t          state_q, state_d;
    logic                  track_we_q, track_we_d;
    logic [LABELWIDTH-1:0] track_label_q, track_label_d;
    logic                  track_mark_q, track_mark_d;

    logic                  w_push, w_pop, w_issue;
    req_t                  w_mark_req, w_clear_req, w_head;
    logic                  w_q_empty, w_drop0, w_drop1;
    logic [QAW:0]          w_q_free;

    assign w_push      = gen_valid_q && gen_ready;
    assign w_pop       = mon_valid && mon_ready;
    assign w_mark_req  = '{mark: c_req_mark,  label: gen_data_q};
    assign w_clear_req = '{mark: c_req_clear, label: mon_data};

    // Mark goes on port 0 so a same-cycle push is always issued before the
    // pop, and the tracker never sees a clear for a label it has not marked.
    dual_push_queue #(
        .WIDTH (LABELWIDTH + 1),
        .AW    (QAW)
    ) u_queue (
        .clk      (clk),
        .rst      (reset),
        .wr0_en   (w_push),
        .wr0_data (w_mark_req),
        .wr1_en   (w_pop),
        .wr1_data (w_clear_req),
        .rd_en    (w_issue),
        .rd_data  (w_head),
        .empty    (w_q_empty),
        .free_cnt (w_q_free),
        .drop0    (w_drop0),
        .drop1    (w_drop1)
    );

    assign w_issue = (state_q == ISSUE_IDLE) && !w_q_empty && !track_fifo_full;

    always_comb begin
        gen_data_d    = gen_data_q + LABELWIDTH'(w_push);
        gen_valid_d   = gen_en && (w_q_free >= (QAW+1)'(c_gen_free_min));
        push_count_d  = push_count_q + 32'(w_push);
        pop_count_d   = pop_count_q + 32'(w_pop);
        tap_ovf_d     = tap_ovf_q || w_drop0 || w_drop1;
        state_d       = state_q;
        track_we_d    = 1'b0;
        track_label_d = track_label_q;
        track_mark_d  = track_mark_q;
        case (state_q)
            ISSUE_IDLE: begin
                if (w_issue) begin
                    track_we_d    = 1'b1;
                    track_label_d = w_head.label;
                    track_mark_d  = w_head.mark;
                    state_d       = ISSUE_GAP;
                end
            end
            ISSUE_GAP: state_d = ISSUE_IDLE;
            default:   state_d = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_data_q    <= '0;
            gen_valid_q   <= 1'b0;
            push_count_q  <= '0;
            pop_count_q   <= '0;
            tap_ovf_q     <= 1'b0;
            state_q       <= ISSUE_IDLE;
            track_we_q    <= 1'b0;
            track_label_q <= '0;
            track_mark_q  <= 1'b0;
        end else begin
            gen_data_q    <= gen_data_d;
            gen_valid_q   <= gen_valid_d;
            push_count_q  <= push_count_d;
            pop_count_q   <= pop_count_d;
            tap_ovf_q     <= tap_ovf_d;
            state_q       <= state_d;
            track_we_q    <= track_we_d;
            track_label_q <= track_label_d;
            track_mark_q  <= track_mark_d;
        end
    end

    assign gen_data      = gen_data_q;
    assign gen_valid     = gen_valid_q;
    assign track_fifo_we = track_we_q;
    assign track_label   = track_label_q;
    assign track_mark    = track_mark_q;
    assign tap_ovf       = tap_ovf_q;
    assign push_count    = push_count_q;
    assign pop_count     = pop_count_q;

endmodule
`default_nettype wire

// File: doc/track_tap.md
# track_tap

Stimulus-and-observation stage that feeds the label-tracking hash table. It generates sequential labels as data into a FIFO under test and records each accepted push as a "mark" request. It observes the FIFO's pop side and records each accepted pop as a "clear" request. Requests are merged in order and issued to the tracking block's write port at no more than one write every other cycle, which is the rate limit that port requires.

## Interface
Parameters:
- LABELWIDTH, 20, label / data width; must match the tracking block.
- QAW, 3, request queue address width; depth is 2^QAW entries, minimum depth 8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- gen_en  in  1  enables label generation.
- gen_data  out  LABELWIDTH  current label presented to the FIFO under test.
- gen_valid  out  1  gen_data valid.
- gen_ready  in  1  FIFO under test accepts; a push occurs when gen_valid && gen_ready.
- mon_data  in  LABELWIDTH  data popped from the FIFO under test.
- mon_valid  in  1  pop side has data.
- mon_ready  in  1  pop side is being read; a pop occurs when mon_valid && mon_ready.
- track_fifo_we  out  1  write strobe to the tracking block.
- track_label  out  LABELWIDTH  label for the write.
- track_mark  out  1  1 = mark (push), 0 = clear (pop).
- track_fifo_full  in  1  tracking request FIFO is full.
- tap_ovf  out  1  sticky; a request was dropped.
- push_count  out  32  accepted pushes; wraps.
- pop_count  out  32  accepted pops; wraps.

## Operation
- **Generator**
  - gen_data starts at 0.
  - Increments by 1 on each push, wrapping modulo 2^LABELWIDTH.
  - gen_valid = gen_en && (queue free entries ≥ 4). It is registered, so the check is evaluated one cycle early.
- **Capture**
  - A push enqueues {1, gen_data}. A pop enqueues {0, mon_data}.
  - Push and pop in the same cycle: both are enqueued, the mark entry ahead of the clear entry. This ordering prevents a false "remove missing label" error.
  - Counters increment on their own event.
- **Queue**
  - FIFO of {mark, label} entries.
  - Up to 2 writes and 1 read per cycle.
  - If an entry finds no free slot, that entry is dropped and tap_ovf is set. In a two-entry cycle, only the overflowing entries are dropped.
  - tap_ovf clears only on reset.
- **Issue FSM** (states ISSUE_IDLE, ISSUE_GAP)
  - ISSUE_IDLE: if the queue is non-empty and track_fifo_full = 0:
    - pop the head;
    - register it onto track_label / track_mark;
    - pulse track_fifo_we for 1 cycle;
    - go to ISSUE_GAP.
  - ISSUE_GAP: track_fifo_we = 0 for exactly one cycle, then return to ISSUE_IDLE.
  - The FSM never issues while track_fifo_full = 1. The sampled value is used, and the head is held until full drops.
- **Reset mid-operation**: queue emptied, FSM to ISSUE_IDLE, generator label back to 0. No partial write is emitted.

## Timing
- **Reset values**: every output is 0. That covers gen_data, gen_valid, track_fifo_we, track_label, track_mark, tap_ovf, push_count and pop_count.
- **Latency**: for an event sampled at edge E into an empty queue with the FSM idle, track_fifo_we is asserted in the cycle after edge E+1, i.e. 2 cycles.
- **Write spacing**: at least one idle cycle between any two track_fifo_we pulses.
- **Throughput**
  - Drain rate is 1 entry per 2 cycles.
  - The generator self-throttles through the free-entry threshold.
  - Pops cannot be throttled. Sustained pop rate above 0.5/cycle eventually sets tap_ovf; this is correct behaviour, not a bug.
- **Label wrap**: after label 2^LABELWIDTH−1 comes 0, with no gap.
- **track_fifo_full**
  - Asserted on the cycle the FSM would issue: no write occurs; retry every idle cycle.
  - Deasserted: a write may occur in the same cycle.

## Structure
- Package track_pkg:
  - LABELWIDTH default;
  - request entry type {mark, label};
  - issue FSM state encoding.
- Sub-module dual_push_queue:
  - parameterised width/depth circular buffer;
  - two write ports with ordered insertion, one read port;
  - free-entry count output;
  - per-port drop flags.
- The generator, counters, issue FSM and ovf logic live in the track_tap top level.

## Test plan
- **Single push then pop**: gen_en=1, gen_ready pulses once, then one pop with mon_data=0 → writes {mark=1,label=0} then {mark=0,label=0}, at least 2 cycles apart; push_count=1, pop_count=1.
- **Simultaneous push (label 5) and pop (data 3)** in one cycle → mark 5 issued before clear 3.
- **Back-to-back pushes** with gen_ready held high for 20 cycles → track_fifo_we pulses every other cycle; gen_valid drops when free entries < 4; tap_ovf stays 0.
- **track_fifo_full held high** for 10 cycles with 3 queued entries → no writes during the hold; the 3 writes follow, spaced 2 cycles apart, after release.
- **Forced pops every cycle** with gen_en=0 → queue fills; tap_ovf=1 and stays set; dropped entries are never issued.
- **Label wrap** with LABELWIDTH=4: 17 pushes → labels 0..15 then 0. Assert reset mid-burst → all outputs 0 and the next push carries label 0.
